// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational (0 latency), halted/timeout are sticky until reset.
// Define PIPE_STALL_CNT_EN to build the saturating stall_cycles counter; otherwise stall_cycles reads 0.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  state_t        state_q;
  logic [WW-1:0] wait_cnt_q;
  logic          halted_q;
  logic          mem_timeout_q;

  logic load_use;
  logic mem_stall;

  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign mem_stall = mem_req && !mem_ready && (state_q != HALTED);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      // all-enabled defaults so the datapath registers take their own reset
    end else if (state_q == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      // EX is frozen, so a masked branch or load-use re-presents after release
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (wb_halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (mem_stall) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_req || mem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WW'(MEM_WAIT_MAX)) begin
            state_q       <= HALTED;
            mem_timeout_q <= 1'b1;
            halted_q      <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != HALTED) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
